// File: rtl/vending_pkg.sv
// Shared types and default configuration for the parametrised coin vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam int DEF_NUM_COINS   = 4;
  localparam int DEF_VAL_W       = 8;
  localparam logic [DEF_NUM_COINS*DEF_VAL_W-1:0] DEF_COIN_VAL = {8'd100, 8'd50, 8'd10, 8'd5};
  localparam int DEF_PRICE       = 125;
  localparam int DEF_CHANGE_UNIT = 5;

endpackage

// File: rtl/coin_edge_sel.sv
// Coin rising-edge detector: flags a single or multiple new insertion and
// looks up the value of the inserted channel.
module coin_edge_sel
  import vending_pkg::*;
#(
  parameter int                           NUM_COINS = DEF_NUM_COINS,
  parameter int                           VAL_W     = DEF_VAL_W,
  parameter logic [NUM_COINS*VAL_W-1:0]   COIN_VAL  = DEF_COIN_VAL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coin_in,
  output logic                 one_edge,
  output logic                 multi_edge,
  output logic [VAL_W-1:0]     coin_val
);

  logic [NUM_COINS-1:0] coin_prev;
  logic [NUM_COINS-1:0] new_edge;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coin_prev <= '0;
    else        coin_prev <= coin_in;
  end

  assign new_edge = coin_in & ~coin_prev;

  // Clearing the lowest set bit leaves something only if two or more edges arrived.
  assign multi_edge = |(new_edge & (new_edge - NUM_COINS'(1)));
  assign one_edge   = (|new_edge) & ~multi_edge;

  always_comb begin
    coin_val = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (new_edge[i]) coin_val = coin_val | COIN_VAL[i*VAL_W +: VAL_W];
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// Parametrised vending controller: credits coins, vends at PRICE, returns change as unit pulses.
// Optional macro VEND_AUTO_CHANGE_EN: return residual credit automatically after a vend.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int                         NUM_COINS   = DEF_NUM_COINS,
  parameter int                         VAL_W       = DEF_VAL_W,
  parameter logic [NUM_COINS*VAL_W-1:0] COIN_VAL    = DEF_COIN_VAL,
  parameter int                         ACC_W       = 8,
  parameter int                         PRICE       = DEF_PRICE,
  parameter int                         CHANGE_UNIT = DEF_CHANGE_UNIT
) (
  input  logic                 CLK,
  input  logic                 n_reset,
  input  logic                 enable,
  input  logic                 cancel,
  input  logic [NUM_COINS-1:0] coin_in,
  output logic                 rel,
  output logic                 chg_pulse,
  output logic                 coin_reject,
  output logic [ACC_W-1:0]     credit,
  output logic                 busy
);

  localparam int SUM_W = ((ACC_W > VAL_W) ? ACC_W : VAL_W) + 1;
  localparam logic [ACC_W-1:0] PRICE_A  = ACC_W'(PRICE);
  localparam logic [ACC_W-1:0] CHANGE_A = ACC_W'(CHANGE_UNIT);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  credit_q, credit_d;
  logic              rel_d, chg_d, reject_d, busy_d;
  logic              one_edge, multi_edge;
  logic [VAL_W-1:0]  coin_val;
  logic [SUM_W-1:0]  sum;
  logic              overflow;

  coin_edge_sel #(
    .NUM_COINS (NUM_COINS),
    .VAL_W     (VAL_W),
    .COIN_VAL  (COIN_VAL)
  ) u_edge (
    .clk        (CLK),
    .rst_n      (n_reset),
    .coin_in    (coin_in),
    .one_edge   (one_edge),
    .multi_edge (multi_edge),
    .coin_val   (coin_val)
  );

  assign sum      = SUM_W'(credit_q) + SUM_W'(coin_val);
  assign overflow = |sum[SUM_W-1:ACC_W];

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rel_d    = 1'b0;
    chg_d    = 1'b0;
    reject_d = one_edge | multi_edge;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end else if (cancel) begin
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (credit_q >= PRICE_A) begin
          state_d = ST_VEND;
        end else if (one_edge && !overflow) begin
          credit_d = sum[ACC_W-1:0];
          reject_d = 1'b0;
        end
      end
      ST_VEND: begin
`ifdef VEND_AUTO_CHANGE_EN
        state_d = (credit_q != '0) ? ST_CHANGE : ST_COLLECT;
`else
        state_d = ST_COLLECT;
`endif
      end
      ST_CHANGE: begin
        if (credit_q == '0) state_d = enable ? ST_COLLECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Actions are applied on entry so the registered outputs line up with the state.
    if (state_d == ST_VEND) begin
      rel_d    = 1'b1;
      credit_d = credit_q - PRICE_A;
    end
    if (state_d == ST_CHANGE) begin
      chg_d    = 1'b1;
      credit_d = credit_q - CHANGE_A;
    end
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      rel         <= 1'b0;
      chg_pulse   <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      rel         <= rel_d;
      chg_pulse   <= chg_d;
      coin_reject <= reject_d;
      busy        <= busy_d;
    end
  end

  assign credit = credit_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: vector table plus hand sequences, scoreboard-compared.
module tb_vending_ctrl;

  logic       CLK = 1'b0;
  logic       n_reset;
  logic       enable, cancel;
  logic [3:0] coin_in;
  logic       rel, chg_pulse, coin_reject, busy;
  logic [7:0] credit;

  logic       s_enable, s_cancel;
  logic [3:0] s_coin;
  logic       s_rel, s_chg, s_rej, s_busy;
  logic [6:0] s_credit;

  typedef struct packed {
    logic       rel;
    logic       chg;
    logic       rej;
    logic [7:0] credit;
    logic       busy;
  } out_t;

  typedef struct {
    logic       en;
    logic       can;
    logic [3:0] coin;
    out_t       exp;
  } vec_t;

  out_t sb[$];
  vec_t tbl[17];
  int   total = 0;
  int   bad   = 0;

  vending_ctrl u_dut (
    .CLK         (CLK),
    .n_reset     (n_reset),
    .enable      (enable),
    .cancel      (cancel),
    .coin_in     (coin_in),
    .rel         (rel),
    .chg_pulse   (chg_pulse),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  vending_ctrl #(.ACC_W(7), .PRICE(127)) u_sat (
    .CLK         (CLK),
    .n_reset     (n_reset),
    .enable      (s_enable),
    .cancel      (s_cancel),
    .coin_in     (s_coin),
    .rel         (s_rel),
    .chg_pulse   (s_chg),
    .coin_reject (s_rej),
    .credit      (s_credit),
    .busy        (s_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t mk(input logic r, input logic c, input logic j,
                              input logic [7:0] cr, input logic b);
    out_t o;
    o.rel = r; o.chg = c; o.rej = j; o.credit = cr; o.busy = b;
    return o;
  endfunction

  // Drives one cycle of stimulus, queues its expectation, compares after the edge.
  task automatic step(input string name, input logic en, input logic can,
                      input logic [3:0] coin, input out_t exp);
    out_t got, want;
    enable  = en;
    cancel  = can;
    coin_in = coin;
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    want = sb.pop_front();
    got  = {rel, chg_pulse, coin_reject, credit, busy};
    check(name, 32'(got), 32'(want));
  endtask

  initial begin
    n_reset  = 1'b0;
    enable   = 1'b0;
    cancel   = 1'b0;
    coin_in  = 4'b0000;
    s_enable = 1'b0;
    s_cancel = 1'b0;
    s_coin   = 4'b0000;

    // Idle rejection, exact vend at 125, edge during transitions, simultaneous edges.
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, mk(0, 0, 0, 8'd0,   0)};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, mk(0, 0, 1, 8'd0,   0)};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, mk(0, 0, 0, 8'd0,   0)};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd0,   0)};
    tbl[4]  = '{1'b1, 1'b0, 4'b1000, mk(0, 0, 0, 8'd100, 0)};
    tbl[5]  = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd100, 0)};
    tbl[6]  = '{1'b1, 1'b0, 4'b0010, mk(0, 0, 0, 8'd110, 0)};
    tbl[7]  = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd110, 0)};
    tbl[8]  = '{1'b1, 1'b0, 4'b0010, mk(0, 0, 0, 8'd120, 0)};
    tbl[9]  = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd120, 0)};
    tbl[10] = '{1'b1, 1'b0, 4'b0001, mk(0, 0, 0, 8'd125, 0)};
    tbl[11] = '{1'b1, 1'b0, 4'b0100, mk(1, 0, 1, 8'd0,   1)};
    tbl[12] = '{1'b1, 1'b0, 4'b0110, mk(0, 0, 1, 8'd0,   0)};
    tbl[13] = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd0,   0)};
    tbl[14] = '{1'b1, 1'b0, 4'b0011, mk(0, 0, 1, 8'd0,   0)};
    tbl[15] = '{1'b1, 1'b0, 4'b0011, mk(0, 0, 0, 8'd0,   0)};
    tbl[16] = '{1'b1, 1'b0, 4'b0000, mk(0, 0, 0, 8'd0,   0)};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", 32'({rel, chg_pulse, coin_reject, credit, busy}), 32'd0);
    n_reset = 1'b1;

    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].can, tbl[i].coin, tbl[i].exp);

    // Overpay 100+50 leaves 25 of residual credit.
    step("over_100",  1, 0, 4'b1000, mk(0, 0, 0, 8'd100, 0));
    step("over_gap",  1, 0, 4'b0000, mk(0, 0, 0, 8'd100, 0));
    step("over_150",  1, 0, 4'b0100, mk(0, 0, 0, 8'd150, 0));
    step("over_vend", 1, 0, 4'b0000, mk(1, 0, 0, 8'd25,  1));
`ifdef VEND_AUTO_CHANGE_EN
    for (int k = 1; k <= 5; k++)
      step($sformatf("auto_chg%0d", k), 1, 0, 4'b0000, mk(0, 1, 0, 8'(25 - 5*k), 1));
    step("auto_done", 1, 0, 4'b0000, mk(0, 0, 0, 8'd0, 0));
`else
    step("keep25_a", 1, 0, 4'b0000, mk(0, 0, 0, 8'd25, 0));
    step("keep25_b", 1, 0, 4'b0000, mk(0, 0, 0, 8'd25, 0));
    for (int k = 1; k <= 5; k++)
      step($sformatf("drain%0d", k), 1, 1, 4'b0000, mk(0, 1, 0, 8'(25 - 5*k), 1));
    step("drain_done", 1, 0, 4'b0000, mk(0, 0, 0, 8'd0, 0));
`endif

    // Cancel refund of 60 as 12 pulses; coins during the transition and CHANGE are rejected.
    step("can_50",  1, 0, 4'b0100, mk(0, 0, 0, 8'd50, 0));
    step("can_gap", 1, 0, 4'b0000, mk(0, 0, 0, 8'd50, 0));
    step("can_60",  1, 0, 4'b0010, mk(0, 0, 0, 8'd60, 0));
    step("can_chg1", 1, 1, 4'b0001, mk(0, 1, 1, 8'd55, 1));
    for (int k = 2; k <= 12; k++)
      step($sformatf("can_chg%0d", k), 1, 1, (k == 5) ? 4'b0100 : 4'b0000,
           mk(0, 1, (k == 5), 8'(60 - 5*k), 1));
    step("can_done", 1, 0, 4'b0000, mk(0, 0, 0, 8'd0, 0));

    // Dropping enable refunds and returns to IDLE.
    step("off_10",   1, 0, 4'b0010, mk(0, 0, 0, 8'd10, 0));
    step("off_chg1", 0, 0, 4'b0000, mk(0, 1, 0, 8'd5,  1));
    step("off_chg2", 0, 0, 4'b0000, mk(0, 1, 0, 8'd0,  1));
    step("off_idle", 0, 0, 4'b0000, mk(0, 0, 0, 8'd0,  0));
    step("off_coin", 0, 0, 4'b0001, mk(0, 0, 1, 8'd0,  0));
    step("off_gap",  0, 0, 4'b0000, mk(0, 0, 0, 8'd0,  0));

    // Cancel with zero credit stays in COLLECT and does not credit coins.
    step("c0_enter", 1, 1, 4'b0000, mk(0, 0, 0, 8'd0, 0));
    step("c0_stay",  1, 1, 4'b0000, mk(0, 0, 0, 8'd0, 0));
    step("c0_coin",  1, 1, 4'b0010, mk(0, 0, 1, 8'd0, 0));
    step("c0_rel",   1, 0, 4'b0000, mk(0, 0, 0, 8'd0, 0));

    // Reset in the middle of CHANGE clears everything at once.
    step("rs_100", 1, 0, 4'b1000, mk(0, 0, 0, 8'd100, 0));
    step("rs_chg", 1, 1, 4'b0000, mk(0, 1, 0, 8'd95,  1));
    #2;
    n_reset = 1'b0;
    enable  = 1'b0;
    cancel  = 1'b0;
    coin_in = 4'b1000;
    #1;
    check("rs_chg_pulse", 32'(chg_pulse), 32'd0);
    check("rs_credit",    32'(credit),    32'd0);
    check("rs_busy",      32'(busy),      32'd0);
    check("rs_rel",       32'(rel),       32'd0);
    @(posedge CLK);
    @(negedge CLK);
    n_reset = 1'b1;
    step("rs_edge", 0, 0, 4'b1000, mk(0, 0, 1, 8'd0, 0));
    step("rs_hold", 0, 0, 4'b1000, mk(0, 0, 0, 8'd0, 0));

    // Narrow accumulator: 100 + 50 would exceed 127, so the coin is refused.
    s_enable = 1'b1;
    @(posedge CLK); #1;
    s_coin = 4'b1000;
    @(posedge CLK); #1;
    check("sat_credit100", 32'(s_credit), 32'd100);
    s_coin = 4'b0000;
    @(posedge CLK); #1;
    s_coin = 4'b0100;
    @(posedge CLK); #1;
    check("sat_reject", 32'(s_rej),    32'd1);
    check("sat_keep",   32'(s_credit), 32'd100);
    check("sat_no_rel", 32'(s_rel),    32'd0);
    s_coin = 4'b0000;
    @(posedge CLK); #1;
    check("sat_hold", 32'(s_credit), 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
